vga_timing_gen: RTL and testbench

//   Generates 640x480@60 Hz VGA raster timing from the 100 MHz board clock.

---
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen.sv | 98 +++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the VGA generator and the pixel pipeline
interface vga_timing_gen_if;
  logic       en;
  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       valid;
  logic       hsync;
  logic       vsync;
  logic       line_start;
  logic       frame_start;

  modport master (
    input  en,
    output pix_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output en,
    input  pix_en, h_cnt, v_cnt, valid, hsync, vsync, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA raster timing with pixel-enable divider
// Decodes are registered from next-state counters so syncs/valid never lag h_cnt/v_cnt.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS   = 10'(H_DISP);
  localparam logic [9:0] V_VIS   = 10'(V_DISP);
  localparam logic [9:0] HS_BEG  = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_DISP + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [9:0]       h_cnt, v_cnt, h_nxt, v_nxt;
  logic             pix_tick, h_wrap, v_wrap;
  logic             pix_en, valid, hsync, vsync, line_start, frame_start;

  assign pix_tick = vif.en && (div_cnt == DIV_LAST);

  always_comb begin
    h_nxt  = h_cnt;
    v_nxt  = v_cnt;
    h_wrap = 1'b0;
    v_wrap = 1'b0;
    if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt  = '0;
        h_wrap = 1'b1;
        if (v_cnt == V_LAST) begin
          v_nxt  = '0;
          v_wrap = 1'b1;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_en      <= 1'b0;
      valid       <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (vif.en) begin
      div_cnt     <= pix_tick ? '0 : div_cnt + DIV_W'(1);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pix_en      <= pix_tick;
      valid       <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hsync       <= ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vsync       <= ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end else begin
      // Paused: position and levels hold, but strobes must not repeat.
      pix_en      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign vif.pix_en      = pix_en;
  assign vif.h_cnt       = h_cnt;
  assign vif.v_cnt       = v_cnt;
  assign vif.valid       = valid;
  assign vif.hsync       = hsync;
  assign vif.vsync       = vsync;
  assign vif.line_start  = line_start;
  assign vif.frame_start = frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: full-size timing on dut0, shrunk raster with SYNC_POL=1 on dut1
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_n0, rst_n1;
  int   tests = 0;
  int   fails = 0;

  vga_timing_gen_if vif0();
  vga_timing_gen_if vif1();

  vga_timing_gen dut0 (.clk(clk), .rst_n(rst_n0), .vif(vif0));
  vga_timing_gen #(
    .CLK_DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) dut1 (.clk(clk), .rst_n(rst_n1), .vif(vif1));

  always #5 clk = ~clk;

  logic [25:0] dvec0, dvec1;
  assign dvec0 = {vif0.pix_en, vif0.h_cnt, vif0.v_cnt, vif0.valid, vif0.hsync,
                  vif0.vsync, vif0.line_start, vif0.frame_start};
  assign dvec1 = {vif1.pix_en, vif1.h_cnt, vif1.v_cnt, vif1.valid, vif1.hsync,
                  vif1.vsync, vif1.line_start, vif1.frame_start};

  // Reference raster for both instances (index 0 = default, 1 = shrunk)
  int c_div[2] = '{4, 2};
  int c_ht[2]  = '{800, 15};
  int c_hd[2]  = '{640, 8};
  int c_hs0[2] = '{656, 10};
  int c_hs1[2] = '{752, 13};
  int c_vt[2]  = '{525, 8};
  int c_vd[2]  = '{480, 4};
  int c_vs0[2] = '{490, 5};
  int c_vs1[2] = '{492, 7};
  bit c_pol[2] = '{1'b0, 1'b1};

  int m_div[2], m_h[2], m_v[2];
  bit m_pix[2], m_ls[2], m_fs[2], m_valid[2], m_hs[2], m_vs[2];

  function automatic void model_reset(int id);
    m_div[id] = 0; m_h[id] = 0; m_v[id] = 0;
    m_pix[id] = 1'b0; m_ls[id] = 1'b0; m_fs[id] = 1'b0; m_valid[id] = 1'b0;
    m_hs[id] = !c_pol[id]; m_vs[id] = !c_pol[id];
  endfunction

  function automatic void model_step(int id, logic rstn, logic en);
    if (!rstn) begin
      model_reset(id);
    end else begin
      m_pix[id] = 1'b0; m_ls[id] = 1'b0; m_fs[id] = 1'b0;
      if (en) begin
        if (m_div[id] == c_div[id] - 1) begin
          m_div[id] = 0;
          m_pix[id] = 1'b1;
          if (m_h[id] == c_ht[id] - 1) begin
            m_h[id] = 0;
            m_ls[id] = 1'b1;
            if (m_v[id] == c_vt[id] - 1) begin
              m_v[id] = 0;
              m_fs[id] = 1'b1;
            end else m_v[id]++;
          end else m_h[id]++;
        end else m_div[id]++;
        m_valid[id] = (m_h[id] < c_hd[id]) && (m_v[id] < c_vd[id]);
        m_hs[id] = (m_h[id] >= c_hs0[id] && m_h[id] < c_hs1[id]) ? c_pol[id] : !c_pol[id];
        m_vs[id] = (m_v[id] >= c_vs0[id] && m_v[id] < c_vs1[id]) ? c_pol[id] : !c_pol[id];
      end
    end
  endfunction

  function automatic logic [25:0] exp_vec(int id);
    return {m_pix[id], 10'(m_h[id]), 10'(m_v[id]), m_valid[id], m_hs[id], m_vs[id],
            m_ls[id], m_fs[id]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(0, rst_n0, vif0.en);
    model_step(1, rst_n1, vif1.en);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] want;
    rst_n0 = 1'b0; rst_n1 = 1'b0; vif0.en = 1'b1; vif1.en = 1'b1;
    model_reset(0); model_reset(1);
    repeat (3) tick();
    want = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tests++;
    if (dvec0 !== want) begin fails++; $display("FAIL reset_dut0 got %h want %h", dvec0, want); end
    want = 26'd0;
    tests++;
    if (dvec1 !== want) begin fails++; $display("FAIL reset_dut1 got %h want %h", dvec1, want); end
  endtask

  task automatic test_first_pixels();
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      tests++;
      if (vif0.pix_en !== ((k % 4) == 0)) begin
        fails++; $display("FAIL first_pix_en clk=%0d got %b want %b", k, vif0.pix_en, (k % 4) == 0);
      end
      tests++;
      if (vif0.h_cnt !== 10'(k / 4)) begin
        fails++; $display("FAIL first_h_cnt clk=%0d got %0d want %0d", k, vif0.h_cnt, k / 4);
      end
      tests++;
      if (vif0.valid !== 1'b1) begin
        fails++; $display("FAIL first_valid clk=%0d got %b want 1", k, vif0.valid);
      end
    end
  endtask

  task automatic test_line_wrap();
    bit done = 1'b0;
    for (int n = 0; n < 4000 && !done; n++) begin
      tick();
      tests++;
      if (dvec0 !== exp_vec(0)) begin
        fails++; $display("FAIL line_vec t=%0t got %h want %h", $time, dvec0, exp_vec(0));
      end
      if (m_pix[0] && m_h[0] == 639) begin
        tests++;
        if (vif0.valid !== 1'b1) begin fails++; $display("FAIL valid_h639 got %b want 1", vif0.valid); end
      end
      if (m_pix[0] && m_h[0] == 640) begin
        tests++;
        if (vif0.valid !== 1'b0) begin fails++; $display("FAIL valid_h640 got %b want 0", vif0.valid); end
      end
      if (m_pix[0] && m_h[0] == 656) begin
        tests++;
        if (vif0.hsync !== 1'b0) begin fails++; $display("FAIL hsync_h656 got %b want 0", vif0.hsync); end
      end
      if (m_pix[0] && m_h[0] == 752) begin
        tests++;
        if (vif0.hsync !== 1'b1) begin fails++; $display("FAIL hsync_h752 got %b want 1", vif0.hsync); end
      end
      if (m_ls[0]) begin
        done = 1'b1;
        tests++;
        if ({vif0.h_cnt, vif0.v_cnt} !== {10'd0, 10'd1}) begin
          fails++; $display("FAIL wrap_pos got h=%0d v=%0d want h=0 v=1", vif0.h_cnt, vif0.v_cnt);
        end
        tests++;
        if ({vif0.line_start, vif0.frame_start} !== 2'b10) begin
          fails++; $display("FAIL wrap_pulses got %b want 10", {vif0.line_start, vif0.frame_start});
        end
        tick();
        tests++;
        if (vif0.line_start !== 1'b0) begin fails++; $display("FAIL line_start_width got %b want 0", vif0.line_start); end
      end
    end
    if (!done) begin tests++; fails++; $display("FAIL line_wrap_timeout got no wrap want wrap"); end
  endtask

  task automatic test_en_freeze();
    bit found = 1'b0;
    for (int n = 0; n < 2000 && !found; n++) begin
      tick();
      if (m_pix[0] && m_h[0] == 300) found = 1'b1;
    end
    if (!found) begin tests++; fails++; $display("FAIL freeze_seek_timeout got none want h=300"); end
    tick();
    vif0.en = 1'b0;
    for (int n = 0; n < 37; n++) begin
      tick();
      tests++;
      if (dvec0 !== exp_vec(0)) begin
        fails++; $display("FAIL freeze_vec n=%0d got %h want %h", n, dvec0, exp_vec(0));
      end
    end
    tests++;
    if ({vif0.pix_en, vif0.h_cnt} !== {1'b0, 10'd300}) begin
      fails++; $display("FAIL freeze_hold got pix=%b h=%0d want pix=0 h=300", vif0.pix_en, vif0.h_cnt);
    end
    vif0.en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      tests++;
      if (vif0.pix_en !== (k == 3 || k == 7)) begin
        fails++; $display("FAIL resume_spacing k=%0d got %b want %b", k, vif0.pix_en, (k == 3 || k == 7));
      end
    end
    tests++;
    if (vif0.h_cnt !== 10'd302) begin fails++; $display("FAIL resume_h got %0d want 302", vif0.h_cnt); end
  endtask

  task automatic test_frame();
    bit found = 1'b0;
    int period = 0, pixcnt = 0;
    for (int n = 0; n < 400 && !found; n++) begin
      tick();
      tests++;
      if (dvec1 !== exp_vec(1)) begin
        fails++; $display("FAIL frame_vec t=%0t got %h want %h", $time, dvec1, exp_vec(1));
      end
      if (m_fs[1]) found = 1'b1;
    end
    if (!found) begin tests++; fails++; $display("FAIL frame_seek_timeout got none want frame_start"); end
    tests++;
    if ({vif1.h_cnt, vif1.v_cnt, vif1.line_start} !== {10'd0, 10'd0, 1'b1}) begin
      fails++; $display("FAIL frame_origin got h=%0d v=%0d ls=%b want 0 0 1", vif1.h_cnt, vif1.v_cnt, vif1.line_start);
    end
    found = 1'b0;
    for (int n = 0; n < 600 && !found; n++) begin
      tick();
      period++;
      if (vif1.pix_en) pixcnt++;
      tests++;
      if (dvec1 !== exp_vec(1)) begin
        fails++; $display("FAIL frame_vec t=%0t got %h want %h", $time, dvec1, exp_vec(1));
      end
      if (m_pix[1] && m_h[1] == 0 && m_v[1] == 4) begin
        tests++;
        if ({vif1.valid, vif1.vsync} !== 2'b00) begin
          fails++; $display("FAIL v_disp_edge got valid=%b vsync=%b want 0 0", vif1.valid, vif1.vsync);
        end
      end
      if (m_pix[1] && m_h[1] == 0 && m_v[1] == 5) begin
        tests++;
        if (vif1.vsync !== 1'b1) begin fails++; $display("FAIL vsync_pos_pol got %b want 1", vif1.vsync); end
      end
      if (vif1.frame_start) found = 1'b1;
    end
    tests++;
    if (period !== 240) begin fails++; $display("FAIL frame_period got %0d want 240", period); end
    tests++;
    if (pixcnt !== 120) begin fails++; $display("FAIL frame_pix_count got %0d want 120", pixcnt); end
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    logic [25:0] want;
    for (int n = 0; n < 3500 && !found; n++) begin
      tick();
      if (m_pix[0] && m_h[0] == 700) found = 1'b1;
    end
    if (!found) begin tests++; fails++; $display("FAIL async_seek_timeout got none want h=700"); end
    #2 rst_n0 = 1'b0;
    model_reset(0);
    #1;
    want = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tests++;
    if (dvec0 !== want) begin fails++; $display("FAIL async_rst_dut0 got %h want %h", dvec0, want); end
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      tick();
      if (m_pix[1] && m_v[1] == 5) found = 1'b1;
    end
    tests++;
    if ({found, vif1.vsync} !== 2'b11) begin
      fails++; $display("FAIL vsync_before_rst got found=%b vsync=%b want 1 1", found, vif1.vsync);
    end
    #2 rst_n1 = 1'b0;
    model_reset(1);
    #1;
    tests++;
    if (dvec1 !== 26'd0) begin fails++; $display("FAIL async_rst_dut1 got %h want 0", dvec1); end
    tick();
    rst_n0 = 1'b1; rst_n1 = 1'b1;
    tick();
    tests++;
    if ({vif0.valid, vif0.line_start, vif0.frame_start, vif0.pix_en} !== 4'b1000) begin
      fails++; $display("FAIL release_no_pulse0 got %b want 1000",
                        {vif0.valid, vif0.line_start, vif0.frame_start, vif0.pix_en});
    end
    tests++;
    if ({vif1.valid, vif1.line_start, vif1.frame_start} !== 3'b100) begin
      fails++; $display("FAIL release_no_pulse1 got %b want 100",
                        {vif1.valid, vif1.line_start, vif1.frame_start});
    end
  endtask

  initial begin
    rst_n0 = 1'b0; rst_n1 = 1'b0;
    vif0.en = 1'b1; vif1.en = 1'b1;
    @(negedge clk);
    test_reset();
    test_first_pixels();
    test_line_wrap();
    test_en_freeze();
    test_frame();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
